// File: rtl/tap_controller_ir.sv
// -----------------------------------------------------------------------------
// tap_controller_ir
//   IEEE 1149.1 TAP controller with instruction register, bypass register and
//   optional 32-bit IDCODE register.
//
//   Configuration macro: TAP_IDCODE_EN
//     defined   -> IDCODE register present, reset opcode = IDCODE_OP
//     undefined -> no IDCODE register, reset opcode = BYPASS_OP,
//                  IDCODE_OP selects BYPASS, SEL_IDCODE tied low
//
//   Ports
//     TCK        TAP clock; rise: state + shift registers, fall: TDO + IR latch
//     TRST       asynchronous active-low reset
//     TMS, TDI   mode select, serial data in
//     USER_TDO   serial out of the external (user) data register
//     TDO/TDO_EN serial data out and its output enable
//     IR         latched instruction
//     SEL_*      one-hot data register select decoded from IR
//     STATE      current 4-bit state code
//     TLR..UPDATE_IR  state decodes
// -----------------------------------------------------------------------------
module tap_controller_ir #(
    parameter int unsigned          IR_WIDTH     = 4,
    parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]  IDCODE_OP    = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  BYPASS_OP    = '1
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                USER_TDO,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [IR_WIDTH-1:0] IR,
    output logic                SEL_BYPASS,
    output logic                SEL_IDCODE,
    output logic                SEL_USER,
    output logic [3:0]          STATE,
    output logic                TLR,
    output logic                RTI,
    output logic                CAPTURE_DR,
    output logic                SHIFT_DR,
    output logic                UPDATE_DR,
    output logic                CAPTURE_IR,
    output logic                SHIFT_IR,
    output logic                UPDATE_IR
);

    typedef enum logic [3:0] {
        StTlr     = 4'hF, StRti     = 4'hC, StSelDr   = 4'h7, StCapDr   = 4'h6,
        StShDr    = 4'h2, StEx1Dr   = 4'h1, StPauseDr = 4'h3, StEx2Dr   = 4'h0,
        StUpdDr   = 4'h5, StSelIr   = 4'h4, StCapIr   = 4'hE, StShIr    = 4'hA,
        StEx1Ir   = 4'h9, StPauseIr = 4'hB, StEx2Ir   = 4'h8, StUpdIr   = 4'hD
    } state_e;

    // Fixed IR capture pattern: bit0 = 1, bit1 = 0, others 0.
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(1);

`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] ResetOp = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] ResetOp = BYPASS_OP;
`endif

    state_e                state_q, state_d;
    logic [IR_WIDTH-1:0]   ir_shift_q;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic                  bypass_q;
    logic                  tdo_q, tdo_d;
    logic                  tdo_en_q, tdo_en_d;
    logic                  sel_bypass, sel_idcode, sel_user;
    logic                  dr_bit0;

    // ---------------- state machine ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:     state_d = TMS ? StTlr   : StRti;
            StRti:     state_d = TMS ? StSelDr : StRti;
            StSelDr:   state_d = TMS ? StSelIr : StCapDr;
            StCapDr:   state_d = TMS ? StEx1Dr : StShDr;
            StShDr:    state_d = TMS ? StEx1Dr : StShDr;
            StEx1Dr:   state_d = TMS ? StUpdDr : StPauseDr;
            StPauseDr: state_d = TMS ? StEx2Dr : StPauseDr;
            StEx2Dr:   state_d = TMS ? StUpdDr : StShDr;
            StUpdDr:   state_d = TMS ? StSelDr : StRti;
            StSelIr:   state_d = TMS ? StTlr   : StCapIr;
            StCapIr:   state_d = TMS ? StEx1Ir : StShIr;
            StShIr:    state_d = TMS ? StEx1Ir : StShIr;
            StEx1Ir:   state_d = TMS ? StUpdIr : StPauseIr;
            StPauseIr: state_d = TMS ? StEx2Ir : StPauseIr;
            StEx2Ir:   state_d = TMS ? StUpdIr : StShIr;
            StUpdIr:   state_d = TMS ? StSelDr : StRti;
            default:   state_d = StTlr;
        endcase
    end

    // ---------------- rising-edge registers ----------------
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q    <= StTlr;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StCapIr) begin
                ir_shift_q <= IrCapture;
            end else if (state_q == StShIr) begin
                ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
            end
            if (sel_bypass) begin
                if (state_q == StCapDr) begin
                    bypass_q <= 1'b0;
                end else if (state_q == StShDr) begin
                    bypass_q <= TDI;
                end
            end
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_q;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            idcode_q <= '0;
        end else if (sel_idcode) begin
            if (state_q == StCapDr) begin
                idcode_q <= IDCODE_VALUE;
            end else if (state_q == StShDr) begin
                idcode_q <= {TDI, idcode_q[31:1]};
            end
        end
    end

    assign sel_bypass = (ir_q == BYPASS_OP);
    assign sel_idcode = !sel_bypass && (ir_q == IDCODE_OP);
`else
    logic unused_idcode_value;
    assign unused_idcode_value = ^IDCODE_VALUE;

    // Without the IDCODE register its opcode falls back to BYPASS.
    assign sel_bypass = (ir_q == BYPASS_OP) || (ir_q == IDCODE_OP);
    assign sel_idcode = 1'b0;
`endif
    assign sel_user = !sel_bypass && !sel_idcode;

    // ---------------- falling-edge outputs / IR latch ----------------
    always_comb begin
        dr_bit0 = USER_TDO;
        if (sel_bypass) begin
            dr_bit0 = bypass_q;
        end
`ifdef TAP_IDCODE_EN
        else if (sel_idcode) begin
            dr_bit0 = idcode_q[0];
        end
`endif
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        ir_d     = ir_q;
        if (state_q == StShIr) begin
            tdo_d    = ir_shift_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == StShDr) begin
            tdo_d    = dr_bit0;
            tdo_en_d = 1'b1;
        end
        if (state_q == StUpdIr) begin
            ir_d = ir_shift_q;
        end else if (state_q == StTlr) begin
            ir_d = ResetOp;
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_q     <= ResetOp;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    // ---------------- outputs ----------------
    assign TDO        = tdo_q;
    assign TDO_EN     = tdo_en_q;
    assign IR         = ir_q;
    assign SEL_BYPASS = sel_bypass;
    assign SEL_IDCODE = sel_idcode;
    assign SEL_USER   = sel_user;
    assign STATE      = state_q;
    assign TLR        = (state_q == StTlr);
    assign RTI        = (state_q == StRti);
    assign CAPTURE_DR = (state_q == StCapDr);
    assign SHIFT_DR   = (state_q == StShDr);
    assign UPDATE_DR  = (state_q == StUpdDr);
    assign CAPTURE_IR = (state_q == StCapIr);
    assign SHIFT_IR   = (state_q == StShIr);
    assign UPDATE_IR  = (state_q == StUpdIr);

endmodule

// File: tb/tb_tap_controller_ir.sv
// -----------------------------------------------------------------------------
// tb_tap_controller_ir
//   Self-checking bench for tap_controller_ir (default parameters). A queue
//   based reference model tracks the TAP and is compared with every output on
//   each TCK low phase; directed scenarios add literal expectations.
//   Honours TAP_IDCODE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tap_controller_ir;

    localparam int IW = 4;
    localparam logic [31:0] IDV = 32'h1000_0001;
    localparam logic [IW-1:0] OP_IDC = 4'h1;
    localparam logic [IW-1:0] OP_BYP = 4'hF;
`ifdef TAP_IDCODE_EN
    localparam logic [IW-1:0] RESET_OP = OP_IDC;
`else
    localparam logic [IW-1:0] RESET_OP = OP_BYP;
`endif

    localparam int S_TLR = 15, S_RTI = 12, S_CAPDR = 6, S_SHDR = 2, S_UPDDR = 5;
    localparam int S_CAPIR = 14, S_SHIR = 10, S_UPDIR = 13, S_PAUSEDR = 3;

    // Next-state lookup by state code, for TMS = 0 and TMS = 1.
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    logic TCK = 1'b0;
    logic TRST, TMS, TDI, USER_TDO;
    logic TDO, TDO_EN, SEL_BYPASS, SEL_IDCODE, SEL_USER;
    logic [IW-1:0] IR;
    logic [3:0] STATE;
    logic TLR, RTI, CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_IR, SHIFT_IR, UPDATE_IR;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    tap_controller_ir dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .USER_TDO(USER_TDO),
        .TDO(TDO), .TDO_EN(TDO_EN), .IR(IR),
        .SEL_BYPASS(SEL_BYPASS), .SEL_IDCODE(SEL_IDCODE), .SEL_USER(SEL_USER),
        .STATE(STATE), .TLR(TLR), .RTI(RTI), .CAPTURE_DR(CAPTURE_DR),
        .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR), .CAPTURE_IR(CAPTURE_IR),
        .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       m_state;
    bit       m_ir[$];      // IR shift register, front = bit0
    bit       m_idc[$];     // IDCODE shift register, front = bit0
    bit       m_byp;
    logic [IW-1:0] m_latch;
    bit       m_tdo, m_en;

    // 0 = bypass, 1 = idcode, 2 = user
    function automatic int m_sel();
        if (m_latch == OP_BYP) return 0;
`ifdef TAP_IDCODE_EN
        if (m_latch == OP_IDC) return 1;
`else
        if (m_latch == OP_IDC) return 0;
`endif
        return 2;
    endfunction

    task automatic m_reset();
        m_state = S_TLR;
        m_latch = RESET_OP;
        m_ir.delete();
        m_idc.delete();
        for (int i = 0; i < IW; i++) m_ir.push_back(1'b0);
        for (int i = 0; i < 32; i++) m_idc.push_back(1'b0);
        m_byp = 0;
        m_tdo = 0;
        m_en  = 0;
    endtask

    task automatic m_rise(input bit tms, input bit tdi);
        if (m_state == S_CAPIR) begin
            m_ir.delete();
            m_ir.push_back(1'b1);
            for (int i = 1; i < IW; i++) m_ir.push_back(1'b0);
        end else if (m_state == S_SHIR) begin
            void'(m_ir.pop_front());
            m_ir.push_back(tdi);
        end else if (m_state == S_CAPDR) begin
            if (m_sel() == 0) m_byp = 0;
            if (m_sel() == 1) begin
                m_idc.delete();
                for (int i = 0; i < 32; i++) m_idc.push_back(IDV[i]);
            end
        end else if (m_state == S_SHDR) begin
            if (m_sel() == 0) m_byp = tdi;
            if (m_sel() == 1) begin
                void'(m_idc.pop_front());
                m_idc.push_back(tdi);
            end
        end
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic m_fall(input bit user_tdo);
        if (m_state == S_UPDIR) begin
            for (int i = 0; i < IW; i++) m_latch[i] = m_ir[i];
        end else if (m_state == S_TLR) begin
            m_latch = RESET_OP;
        end
        m_tdo = 0;
        m_en  = 0;
        if (m_state == S_SHIR) begin
            m_tdo = m_ir[0];
            m_en  = 1;
        end else if (m_state == S_SHDR) begin
            m_en  = 1;
            case (m_sel())
                0: m_tdo = m_byp;
                1: m_tdo = m_idc[0];
                default: m_tdo = user_tdo;
            endcase
        end
    endtask

    always @(negedge TRST) m_reset();
    always @(posedge TCK) if (TRST === 1'b1) m_rise(TMS, TDI);
    always @(negedge TCK) if (TRST === 1'b1) m_fall(USER_TDO);

    // Per-cycle compare in the TCK low phase, after both edges have settled.
    always @(negedge TCK) begin
        #2;
        if (cmp_en) begin
            chk("STATE", STATE, m_state);
            chk("TLR", TLR, m_state == 15);
            chk("RTI", RTI, m_state == 12);
            chk("CAPTURE_DR", CAPTURE_DR, m_state == 6);
            chk("SHIFT_DR", SHIFT_DR, m_state == 2);
            chk("UPDATE_DR", UPDATE_DR, m_state == 5);
            chk("CAPTURE_IR", CAPTURE_IR, m_state == 14);
            chk("SHIFT_IR", SHIFT_IR, m_state == 10);
            chk("UPDATE_IR", UPDATE_IR, m_state == 13);
            chk("IR", IR, m_latch);
            chk("SEL_BYPASS", SEL_BYPASS, m_sel() == 0);
            chk("SEL_IDCODE", SEL_IDCODE, m_sel() == 1);
            chk("SEL_USER", SEL_USER, m_sel() == 2);
            chk("TDO", TDO, m_tdo);
            chk("TDO_EN", TDO_EN, m_en);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns 3 time units after the falling edge (2 before the next rise).
    task automatic tick(input bit tms, input bit tdi);
        TMS      = tms;
        TDI      = tdi;
        USER_TDO = 1'($urandom_range(0, 1));
        @(posedge TCK);
        @(negedge TCK);
        #3;
    endtask

    task automatic load_ir(input logic [IW-1:0] v);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IW; i++) tick(i == IW - 1, v[i]);
        tick(1, 0); tick(0, 0);
    endtask

    task automatic goto_shdr();
        tick(1, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic exit_dr();
        tick(1, 0); tick(1, 0); tick(0, 0);
    endtask

    logic [3:0]  seq;
    logic [35:0] got;
    logic [35:0] tdi_pat;
    logic [3:0]  byp_pat;
    logic [7:0]  path;
    int          plen;

    initial begin
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; USER_TDO = 1'b0;
        m_reset();
        #12;
        chk("reset STATE", STATE, 4'hF);
        chk("reset IR", IR, RESET_OP);
        chk("reset TDO_EN", TDO_EN, 1'b0);
        chk("reset TLR", TLR, 1'b1);
        TRST = 1'b1;
        cmp_en = 1;
        tick(0, 0);
        chk("first rise RTI", STATE, 4'hC);

        // IR scan of zeros: captured 0001 comes out LSB first.
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        seq[0] = TDO;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, 0);
            if (i < 3) seq[i+1] = TDO;
        end
        chk("IR scan TDO seq", {28'h0, seq}, 32'h1);
        tick(1, 0);
        chk("IR after update", IR, 4'h0);
        chk("SEL_USER after IR=0", SEL_USER, 1'b1);
        tick(0, 0);

        // User DR scan: TDO follows USER_TDO.
        goto_shdr();
        for (int i = 0; i < 6; i++) tick(0, 1'($urandom_range(0, 1)));
        exit_dr();

        // Five TMS=1 rises reach TLR from assorted states.
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin path = 8'b0000_0001; plen = 3; end // ShDR
                1: begin path = 8'b0001_0011; plen = 6; end // PauseIR
                2: begin path = 8'b0000_1101; plen = 4; end // UpdDR
                default: begin path = 8'b0001_0101; plen = 5; end // Ex2DR
            endcase
            for (int i = 0; i < plen; i++) tick(path[i], 0);
            for (int i = 0; i < 5; i++) tick(1, 1);
            chk("5xTMS STATE", STATE, 4'hF);
            chk("5xTMS TLR", TLR, 1'b1);
            chk("5xTMS IR", IR, RESET_OP);
            tick(0, 0);
            if (k == 0) load_ir(4'h0);
        end

`ifdef TAP_IDCODE_EN
        // IDCODE scan after reset opcode reload.
        tdi_pat = 36'h9_A5C3_0F96;
        goto_shdr();
        for (int i = 0; i < 36; i++) begin
            got[i] = TDO;
            tick(0, tdi_pat[i]);
        end
        chk("IDCODE word", got[31:0], IDV);
        chk("IDCODE tail echo", {28'h0, got[35:32]}, {28'h0, tdi_pat[3:0]});
        exit_dr();
`endif

        // Pause in DR scan: contents must survive three pause cycles.
        goto_shdr();
        for (int i = 0; i < 27; i++) tick(0, 0);
        tick(1, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            chk("pause STATE", STATE, 4'h3);
            chk("pause TDO_EN", TDO_EN, 1'b0);
        end
        tick(1, 0);
        tick(0, 0);
        chk("after pause TDO", TDO, 1'b1);
        tick(0, 0);
        chk("after pause TDO+1", TDO, 1'b0);
        exit_dr();

        // Bypass: one-cycle delay of TDI.
        load_ir(4'hF);
        chk("IR=F", IR, 4'hF);
        chk("SEL_BYPASS", SEL_BYPASS, 1'b1);
        byp_pat = 4'b1101;  // TDI order 1,0,1,1 from bit0
        goto_shdr();
        for (int i = 0; i < 4; i++) begin
            seq[i] = TDO;
            tick(0, byp_pat[i]);
        end
        chk("bypass TDO seq", {28'h0, seq}, 32'hA);  // 0,1,0,1 from bit0
        exit_dr();

        // Asynchronous reset in the middle of a DR shift.
        load_ir(4'h0);
        goto_shdr();
        tick(0, 1); tick(0, 0);
        TRST = 1'b0;
        #1;
        chk("async rst STATE", STATE, 4'hF);
        chk("async rst IR", IR, RESET_OP);
        chk("async rst TDO_EN", TDO_EN, 1'b0);
        chk("async rst TDO", TDO, 1'b0);
        @(negedge TCK);
        #1 TRST = 1'b1;
        tick(0, 0);
        chk("post rst RTI", STATE, 4'hC);

        // Reset in the middle of an IR shift must not take partial data.
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 0); tick(0, 0);
        TRST = 1'b0;
        #1;
        chk("IR rst mid-shift", IR, RESET_OP);
        chk("IR rst STATE", STATE, 4'hF);
        @(negedge TCK);
        #1 TRST = 1'b1;
        tick(0, 0);
        chk("IR rst then RTI IR", IR, RESET_OP);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_controller_ir.md
TAP_CONTROLLER_IR -- requirements
Module: tap_controller_ir

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register width (>=2).
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1000_0001, IDCODE capture word (bit0 SHALL be 1).
REQ-003 SHALL have parameter IDCODE_OP, default 1, IDCODE opcode (IR_WIDTH bits).
REQ-004 SHALL have parameter BYPASS_OP, default all-ones, BYPASS opcode.
REQ-005 SHALL have ports:
- TCK  in  1  TAP clock; rising edge state/shift, falling edge TDO/update.
- TRST  in  1  asynchronous, active-low reset.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- USER_TDO  in  1  serial out of external data register.
- TDO  out  1  serial data out.
- TDO_EN  out  1  TDO output enable.
- IR  out  IR_WIDTH  latched instruction.
- SEL_BYPASS, SEL_IDCODE, SEL_USER  out  1 each  one-hot DR select.
- STATE  out  4  current state code.
- TLR, RTI, CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_IR, SHIFT_IR, UPDATE_IR  out  1 each  state decodes.

Function
REQ-006 SHALL implement the 16-state IEEE 1149.1 FSM, advanced on TCK rise by TMS; codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
REQ-007 Unused/illegal codes SHALL not occur; default branch SHALL go to TLR.
REQ-008 State decode outputs SHALL be pure decodes of the state register, exactly one active per state named; CAPTURE_DR SHALL assert only in CapDR.
REQ-009 Five consecutive TMS=1 rises SHALL reach TLR from any state.
REQ-010 IR shift register: CapIR rise loads {0..0,1,0...}, i.e. bit0=1, bit1=0, others 0; ShIR rise shifts right, TDI into MSB.
REQ-011 IR latch SHALL load shift register on TCK fall while in UpdIR; SHALL load reset opcode on TCK fall while in TLR.
REQ-012 Select decode from IR latch: BYPASS_OP -> SEL_BYPASS; IDCODE_OP -> SEL_IDCODE; any other -> SEL_USER; exactly one high at all times.
REQ-013 Bypass register: CapDR with SEL_BYPASS loads 0; ShDR shifts in TDI.
REQ-014 IDCODE register (32 bits): CapDR with SEL_IDCODE loads IDCODE_VALUE; ShDR shifts right, TDI into bit31.
REQ-015 TDO and TDO_EN SHALL update on TCK fall: in ShIR TDO=IR shift bit0; in ShDR TDO=selected DR bit0 (USER_TDO if SEL_USER); TDO_EN=1 only in ShIR/ShDR; otherwise TDO=0, TDO_EN=0.
REQ-016 Non-selected data registers SHALL hold value in CapDR/ShDR.
REQ-017 Pause/Exit states SHALL hold all shift registers.

Reset
REQ-018 TRST low SHALL immediately force: state TLR, IR latch = reset opcode, IR shift 0, bypass 0, IDCODE shift 0, TDO 0, TDO_EN 0.
REQ-019 Reset mid-shift SHALL abandon the shift; IR SHALL not take partial data.
REQ-020 First TCK rise after TRST release with TMS=0 SHALL enter RTI.

Configuration
REQ-021 Macro TAP_IDCODE_EN: defined -> IDCODE register present, reset opcode = IDCODE_OP.
REQ-022 Undefined -> no IDCODE register, reset opcode = BYPASS_OP, IDCODE_OP decodes as SEL_BYPASS, SEL_IDCODE tied 0.

Verification
REQ-023 TRST pulse low mid-ShDR -> STATE=F, IR=1 (with TAP_IDCODE_EN) or 4'hF (without), TDO_EN=0 asynchronously.
REQ-024 From RTI, TMS 1,1,0,0 then ShIR 4 bits TDI=0 -> TDO sequence 1,0,0,0; after UpdIR IR=0, SEL_USER=1.
REQ-025 After reset (TAP_IDCODE_EN), go to ShDR, shift 32 bits -> TDO reproduces 32'h1000_0001 LSB first; bits 33+ echo TDI.
REQ-026 Load IR=4'hF, ShDR TDI pattern 1,0,1,1 -> TDO 0,1,0,1 (one-cycle bypass delay).
REQ-027 Any state, TMS=1 for 5 rises -> STATE=F, TLR=1, IR = reset opcode after next fall.
REQ-028 ShDR to Ex1DR to PauseDR for 3 cycles to Ex2DR to ShDR -> IDCODE shift contents unchanged across pause, TDO_EN low during pause.
